// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the per-line sprite scanner.
//   sprite_t      - 25-bit packed descriptor {id[4:0], y[9:0], x[9:0]}
//   scan_state_e  - scanner FSM states
//   sprite_hits() - true when a descriptor covers a given target line
package sprite_pkg;

    typedef struct packed {
        logic [4:0] id;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_t;

    localparam logic [4:0]  ID_NONE             = 5'd0;
    localparam int unsigned SPRITE_SLOTS        = 3;
    localparam int unsigned SPRITE_H_DEFAULT    = 32;
    localparam int unsigned NUM_SPRITES_DEFAULT = 20;

    // Video timing
    localparam int unsigned SCAN_H_DEFAULT   = 640;
    localparam int unsigned COMMIT_H_DEFAULT = 799;
    localparam int unsigned COMMIT_V_DEFAULT = 480;
    localparam int unsigned V_TOTAL_DEFAULT  = 525;

    typedef enum logic [1:0] {StIdle, StScan, StDone} scan_state_e;

    // 11-bit compare so y + height - 1 never wraps past line 1023.
    function automatic logic sprite_hits(sprite_t e, logic [9:0] t, logic [10:0] h);
        logic [10:0] top;
        logic [10:0] bot;
        logic [10:0] tl;
        top = {1'b0, e.y};
        tl  = {1'b0, t};
        bot = top + h - 11'd1;
        return (e.id != ID_NONE) && (top <= tl) && (tl <= bot);
    endfunction

endpackage

// File: rtl/sprite_table.sv
// sprite_table: double-buffered descriptor table.
//   clk, reset             - clock, synchronous active-high reset
//   chipselect, write,
//   address, writedata     - Avalon-MM write port into the shadow copy
//   commit_req             - one-cycle request to copy shadow -> active
//   fsm_idle               - commit only allowed while the scanner is idle
//   rd_idx / rd_entry      - combinational read port into the active copy
module sprite_table
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = NUM_SPRITES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [4:0]  address,
    input  logic [31:0] writedata,
    input  logic        commit_req,
    input  logic        fsm_idle,
    input  logic [4:0]  rd_idx,
    output sprite_t     rd_entry
);

    sprite_t shadow_q [NUM_SPRITES];
    sprite_t active_q [NUM_SPRITES];
    logic    pending_q;
    logic    wr_en;
    logic    do_commit;
    logic    unused_wd;

    assign unused_wd = ^writedata[31:25];
    assign wr_en     = chipselect && write && (32'(address) < NUM_SPRITES);
    // A commit arriving mid-scan is held until the scanner is back in idle.
    assign do_commit = (commit_req || pending_q) && fsm_idle;
    assign rd_entry  = active_q[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            pending_q <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_q[address] <= sprite_t'(writedata[24:0]);
            end
            // Copies the pre-write shadow; a same-cycle write waits a frame.
            if (do_commit) begin
                active_q <= shadow_q;
            end
            pending_q <= (commit_req || pending_q) && !fsm_idle;
        end
    end

endmodule

// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: scans the sprite table during h-blank for the first three
// sprites covering the next line and presents them to the renderer.
//   clk, reset                  - clock, synchronous active-high reset
//   chipselect, write, address,
//   writedata                   - Avalon-MM table writes (no readback)
//   VGA_HCOUNT, VGA_VCOUNT      - current pixel column / line
//   sprite1..sprite3            - selected descriptors, lowest table index first
//   ovf_count                   - only with SPRITE_OVF_CNT_EN: saturating count of
//                                 lines that had more than three hits
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = NUM_SPRITES_DEFAULT,
    parameter int unsigned SPRITE_H    = SPRITE_H_DEFAULT,
    parameter int unsigned SCAN_H      = SCAN_H_DEFAULT,
    parameter int unsigned COMMIT_H    = COMMIT_H_DEFAULT,
    parameter int unsigned COMMIT_V    = COMMIT_V_DEFAULT,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [4:0]  address,
    input  logic [31:0] writedata,
    input  logic [9:0]  VGA_HCOUNT,
    input  logic [9:0]  VGA_VCOUNT,
    output logic [24:0] sprite1,
    output logic [24:0] sprite2,
    output logic [24:0] sprite3
`ifdef SPRITE_OVF_CNT_EN
    ,
    output logic [15:0] ovf_count
`endif
);

    scan_state_e state_q, state_d;

    logic    scan_eq, scan_eq_q, scan_trig;
    logic    hcom_eq, hcom_eq_q, hcom_trig;
    logic    vcom_eq, vcom_eq_q, vcom_trig;
    logic    start_scan, scan_step, load_out, last_idx, entry_hit;
    logic [4:0] idx_q;
    logic [1:0] cnt_q;
    logic [9:0] target_q, target_next;
    sprite_t rd_entry;
    sprite_t staging_q [SPRITE_SLOTS];

    // Triggers fire only on the first cycle a count matches its target.
    assign scan_eq   = VGA_HCOUNT == 10'(SCAN_H);
    assign hcom_eq   = VGA_HCOUNT == 10'(COMMIT_H);
    assign vcom_eq   = VGA_VCOUNT == 10'(COMMIT_V);
    assign scan_trig = scan_eq && !scan_eq_q;
    assign hcom_trig = hcom_eq && !hcom_eq_q;
    assign vcom_trig = vcom_eq && !vcom_eq_q;

    assign target_next = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 10'd0 : VGA_VCOUNT + 10'd1;
    assign last_idx    = idx_q == 5'(NUM_SPRITES - 1);
    assign entry_hit   = sprite_hits(rd_entry, target_q, 11'(SPRITE_H));

    sprite_table #(
        .NUM_SPRITES (NUM_SPRITES)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .commit_req (vcom_trig),
        .fsm_idle   (state_q == StIdle),
        .rd_idx     (idx_q),
        .rd_entry   (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            scan_eq_q <= 1'b0;
            hcom_eq_q <= 1'b0;
            vcom_eq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_eq_q <= scan_eq;
            hcom_eq_q <= hcom_eq;
            vcom_eq_q <= vcom_eq;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (scan_trig) state_d = StScan;
            StScan:  if (last_idx)  state_d = StDone;
            StDone:  if (hcom_trig) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_scan = (state_q == StIdle) && scan_trig;
        scan_step  = state_q == StScan;
        load_out   = (state_q == StDone) && hcom_trig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            target_q  <= '0;
            staging_q <= '{default: '0};
            sprite1   <= '0;
            sprite2   <= '0;
            sprite3   <= '0;
        end else begin
            if (start_scan) begin
                idx_q     <= '0;
                cnt_q     <= '0;
                target_q  <= target_next;
                staging_q <= '{default: '0};
            end else if (scan_step) begin
                if (entry_hit && cnt_q != 2'd3) begin
                    staging_q[cnt_q] <= rd_entry;
                    cnt_q            <= cnt_q + 2'd1;
                end
                if (!last_idx) begin
                    idx_q <= idx_q + 5'd1;
                end
            end
            if (load_out) begin
                sprite1 <= staging_q[0];
                sprite2 <= staging_q[1];
                sprite3 <= staging_q[2];
            end
        end
    end

`ifdef SPRITE_OVF_CNT_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (start_scan) begin
                ovf_q <= 1'b0;
            end else if (scan_step && entry_hit && cnt_q == 2'd3) begin
                ovf_q <= 1'b1;
            end
            if (load_out && ovf_q && ovf_count != 16'hFFFF) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sprite_line_scanner.sv
module tb_sprite_line_scanner;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [24:0] s1, s2, s3;
`ifdef SPRITE_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    always #5 clk = ~clk;

    sprite_line_scanner dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .VGA_HCOUNT (hc),
        .VGA_VCOUNT (vc),
        .sprite1    (s1),
        .sprite2    (s2),
        .sprite3    (s3)
`ifdef SPRITE_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [74:0] exp_q [$];
    logic [74:0] last_out;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] desc(input int id, input int y, input int x);
        return {5'(id), 10'(y), 10'(x)};
    endfunction

    task automatic wr(input int a, input logic [24:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 5'(a);
        writedata  = {7'h7F, d};
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic commit;
        vc = 10'd480;
        tick();
        vc = 10'd0;
        tick();
    endtask

    // mode 1: pulse the frame-commit line mid-scan; mode 2: re-pulse SCAN_H mid-scan.
    task automatic do_line(input int v, input logic [24:0] e1, input logic [24:0] e2,
                           input logic [24:0] e3, input int mode, input string tag);
        logic [74:0] got_exp;
        exp_q.push_back({e1, e2, e3});
        vc = 10'(v);
        hc = 10'd640;
        tick();
        hc = 10'd641;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (mode == 1 && i == 8) vc = 10'd480;
            if (mode == 1 && i == 9) vc = 10'(v);
            if (mode == 2 && i == 8) hc = 10'd640;
            if (mode == 2 && i == 9) hc = 10'd641;
        end
        check_eq({tag, "_hold"}, 32'({s1, s2, s3} != last_out), 32'd0);
        hc = 10'd799;
        tick();
        got_exp = exp_q.pop_front();
        check_eq({tag, "_s1"}, 32'(s1), 32'(got_exp[74:50]));
        check_eq({tag, "_s2"}, 32'(s2), 32'(got_exp[49:25]));
        check_eq({tag, "_s3"}, 32'(s3), 32'(got_exp[24:0]));
        last_out = got_exp;
        hc = 10'd0;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        hc         = '0;
        vc         = '0;
        last_out   = '0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_s1", 32'(s1), 32'd0);
        check_eq("rst_s2", 32'(s2), 32'd0);
        check_eq("rst_s3", 32'(s3), 32'd0);

        // Single sprite; invisible until committed
        wr(0, desc(1, 100, 50));
        do_line(99, '0, '0, '0, 0, "precommit");
        commit();
        do_line(99, desc(1, 100, 50), '0, '0, 0, "single");

        // Four hits, first three by index kept
        wr(0, '0);
        wr(2, desc(1, 200, 2));
        wr(5, desc(2, 200, 5));
        wr(7, desc(3, 200, 7));
        wr(9, desc(1, 200, 9));
        commit();
        do_line(199, desc(1, 200, 2), desc(2, 200, 5), desc(3, 200, 7), 0, "ovf");
`ifdef SPRITE_OVF_CNT_EN
        check_eq("ovf_count", 32'(ovf_count), 32'd1);
`endif

        // Vertical extent boundaries: lines 100..131
        wr(2, '0);
        wr(5, '0);
        wr(7, '0);
        wr(9, '0);
        wr(3, desc(2, 100, 77));
        commit();
        do_line(98,  '0, '0, '0, 0, "above");
        do_line(99,  desc(2, 100, 77), '0, '0, 0, "first_line");
        do_line(130, desc(2, 100, 77), '0, '0, 0, "last_line");
        do_line(131, '0, '0, '0, 0, "below");

        // Target wrap at end of frame; id 0 never hits
        wr(3, '0);
        wr(4, desc(3, 0, 10));
        wr(6, desc(0, 0, 20));
        commit();
        do_line(524, desc(3, 0, 10), '0, '0, 0, "wrap");
        do_line(523, '0, '0, '0, 0, "no_wrap");

        // Write coinciding with commit lands in shadow only
        vc         = 10'd480;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 5'd4;
        writedata  = {7'h00, desc(3, 300, 10)};
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        vc         = 10'd0;
        tick();
        do_line(524, desc(3, 0, 10), '0, '0, 0, "same_cyc_old");
        commit();
        do_line(299, desc(3, 300, 10), '0, '0, 0, "same_cyc_new");
        do_line(524, '0, '0, '0, 0, "old_gone");
        wr(25, desc(1, 0, 5));
        commit();
        do_line(524, '0, '0, '0, 0, "addr_oob");

        // Commit during a scan is deferred; re-trigger during a scan is ignored
        wr(0, desc(1, 50, 1));
        do_line(49, '0, '0, '0, 1, "defer_scan");
        do_line(49, desc(1, 50, 1), '0, '0, 2, "deferred");

        // Reset mid-scan at idx 10
        vc = 10'd49;
        hc = 10'd640;
        tick();
        hc = 10'd641;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_s1", 32'(s1), 32'd0);
        check_eq("midrst_s2", 32'(s2), 32'd0);
        check_eq("midrst_s3", 32'(s3), 32'd0);
        hc       = 10'd0;
        last_out = '0;
        tick();
        commit();
        do_line(49, '0, '0, '0, 0, "cleared");
        wr(1, desc(2, 60, 7));
        commit();
        do_line(59, desc(2, 60, 7), '0, '0, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
